// File: rtl/meas_pkg.sv
// Shared types and constants for the slow-signal measurement blocks.
package meas_pkg;

    typedef enum logic {
        IDLE    = 1'b0,
        MEASURE = 1'b1
    } meas_state_t;

    localparam int unsigned CLK_HZ          = 100_000_000;
    // Seven seconds of silence at the system clock rate.
    localparam int unsigned TIMEOUT_DEFAULT = 7 * CLK_HZ;

endpackage

// File: rtl/sync_edge.sv
// Two-flop synchroniser plus history flop for a slow asynchronous input,
// producing single-cycle rise/fall strobes in the clk domain.
module sync_edge (
    input  logic clk,
    input  logic rst_n,
    input  logic async_i,
    output logic rise_o,
    output logic fall_o
);

    logic s1_q;
    logic s2_q;
    logic s3_q;

    // NOTE: non-blocking assignments so each stage samples the previous
    // stage's value from before the edge, giving a true shift chain.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
            s3_q <= 1'b0;
        end else begin
            s1_q <= async_i;
            s2_q <= s1_q;
            s3_q <= s2_q;
        end
    end

    assign rise_o = s2_q & ~s3_q;
    assign fall_o = ~s2_q & s3_q;

endmodule

// File: rtl/period_meter.sv
// Measures period and high time of a slow square wave in clk cycles and
// flags loss of the signal when no rising edge arrives within TIMEOUT cycles.
module period_meter
    import meas_pkg::*;
#(
    parameter int          CNT_W   = 32,
    parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             sig_in,
    output logic [CNT_W-1:0] period,
    output logic [CNT_W-1:0] high_time,
    output logic             valid,
    output logic             locked,
    output logic             timeout
);

    localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] ONE       = CNT_W'(1);

    logic rise;
    logic fall;

    meas_state_t      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] hi_q, hi_d;
    logic [CNT_W-1:0] period_q, period_d;
    logic [CNT_W-1:0] high_time_q, high_time_d;
    logic             valid_q, valid_d;
    logic             locked_q, locked_d;
    logic             timeout_q, timeout_d;

    sync_edge u_sync_edge (
        .clk     (clk),
        .rst_n   (rst_n),
        .async_i (sig_in),
        .rise_o  (rise),
        .fall_o  (fall)
    );

    // NOTE: every _d takes a default before the case statement, so no path
    // through this block leaves a signal unassigned and no latch is inferred.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        hi_d        = hi_q;
        period_d    = period_q;
        high_time_d = high_time_q;
        valid_d     = 1'b0;
        locked_d    = locked_q;
        timeout_d   = 1'b0;

        unique case (state_q)
            IDLE: begin
                // The first rise only arms the counter; no result exists yet.
                cnt_d = '0;
                if (rise) begin
                    cnt_d   = ONE;
                    state_d = MEASURE;
                end
            end
            MEASURE: begin
                cnt_d = cnt_q + ONE;
                if (fall) begin
                    hi_d = cnt_q;
                end
                // A rise on the timeout cycle still counts as a full period.
                if (rise) begin
                    period_d    = cnt_q;
                    high_time_d = hi_q;
                    valid_d     = 1'b1;
                    locked_d    = 1'b1;
                    cnt_d       = ONE;
                end else if (cnt_q == TIMEOUT_C) begin
                    timeout_d = 1'b1;
                    locked_d  = 1'b0;
                    cnt_d     = '0;
                    state_d   = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            hi_q        <= '0;
            period_q    <= '0;
            high_time_q <= '0;
            valid_q     <= 1'b0;
            locked_q    <= 1'b0;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            hi_q        <= hi_d;
            period_q    <= period_d;
            high_time_q <= high_time_d;
            valid_q     <= valid_d;
            locked_q    <= locked_d;
            timeout_q   <= timeout_d;
        end
    end

    assign period    = period_q;
    assign high_time = high_time_q;
    assign valid     = valid_q;
    assign locked    = locked_q;
    assign timeout   = timeout_q;

endmodule
